approx_err_monitor: RTL and testbench
=====================================

APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

Interface
REQ-001 SHALL have parameter N, default 8: operand width of the multiplier under test.
REQ-002 SHALL have parameter P, default 2*N: product width.
REQ-003 SHALL have parameter CNT_W, default 20: sample-counter width.
REQ-004 SHALL have parameter FRAC, default 16: fractional bits of the relative-error quotient.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1: clock, rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-008 SHALL have port start, input, 1: single-cycle pulse that clears the accumulators and begins a run.
REQ-009 SHALL have port num_samples, input, CNT_W: samples per run, sampled on start.
REQ-010 SHALL have port in_valid, input, 1: approx_p and exact_p are valid.
REQ-011 SHALL have port in_ready, output, 1: block accepts a sample.
REQ-012 SHALL have port approx_p, input, P: approximate product.
REQ-013 SHALL have port exact_p, input, P: exact product.
REQ-014 SHALL have ports busy and done, outputs, 1 each: run in progress; results final.
REQ-015 SHALL have port sum_ed, output, P+CNT_W: sum of error distances.
REQ-016 SHALL have port max_ed, output, P: maximum error distance.
REQ-017 SHALL have ports max_approx and max_exact, outputs, P each: operands of the max_ed sample.
REQ-018 SHALL have ports err_cnt and zero_cnt, outputs, CNT_W each: samples with ED≠0; samples with exact_p=0.
REQ-019 SHALL have port sum_red, output, P+FRAC+CNT_W: sum of fixed-point relative errors.

Function
REQ-020 SHALL implement FSM states IDLE, ACCEPT, DIVIDE, DONE.
REQ-021 SHALL, in IDLE or DONE on start: clear all result outputs, load num_samples, and go to ACCEPT next cycle; if num_samples=0, go to DONE instead.
REQ-022 SHALL ignore start in ACCEPT and DIVIDE.
REQ-023 SHALL assert in_ready only in ACCEPT; a sample is accepted on a clock edge where in_valid and in_ready are both 1.
REQ-024 SHALL compute ED = |approx_p - exact_p| (unsigned, P bits) on acceptance.
REQ-025 SHALL, on acceptance, add ED to sum_ed and increment err_cnt if ED≠0.
REQ-026 SHALL update max_ed/max_approx/max_exact only when ED > max_ed, so the first sample is kept on ties.
REQ-027 SHALL, if exact_p=0, increment zero_cnt and leave sum_red unchanged, with no divide.
REQ-028 SHALL, if ED=0 and exact_p≠0, add 0 to sum_red, with no divide.
REQ-029 SHALL, otherwise, enter DIVIDE and compute floor((ED<<FRAC)/exact_p) with a 1-bit-per-cycle restoring divider over exactly P+FRAC cycles, then add the quotient to sum_red.
REQ-030 SHALL hold in_ready low throughout DIVIDE.
REQ-031 SHALL give a next-accept latency of 1 cycle for a no-divide sample and P+FRAC+1 cycles for a divide sample.
REQ-032 SHALL decrement the remaining-sample counter on acceptance, and after the final sample's accumulation (including any divide) go to DONE on the next edge.
REQ-033 SHALL hold done=1 and all results stable in DONE until start or rst.
REQ-034 SHALL drive busy=1 exactly in ACCEPT and DIVIDE.
REQ-035 SHALL size the accumulators so they cannot overflow for 2^CNT_W-1 samples; no saturation or wrap logic is required.

Reset
REQ-036 SHALL, on rst=1 at a clock edge (including mid-DIVIDE), go to IDLE and zero all outputs, counters and divider state; in_ready, busy and done SHALL be 0.
REQ-037 SHALL give rst priority over start.

Verification
REQ-038 SHALL cover: rst for 2 cycles -> all outputs 0, state IDLE.
REQ-039 SHALL cover (N=8, FRAC=16): start with num_samples=1, sample (100,100) -> sum_ed=0, err_cnt=0, sum_red=0, done=1 one cycle after accept.
REQ-040 SHALL cover: num_samples=1, sample (90,100) -> in_ready low 32 cycles, sum_ed=10, sum_red=6553, err_cnt=1, max_ed=10.
REQ-041 SHALL cover: num_samples=2, samples (5,0) then (130,150) -> zero_cnt=1, sum_ed=25, max_ed=20, max_approx=130, sum_red=8738.
REQ-042 SHALL cover a tie: samples (80,100) then (220,200) -> max_ed=20, max_approx=80, max_exact=100.
REQ-043 SHALL cover: num_samples=0 -> done next cycle with all results 0; separately, rst asserted mid-DIVIDE -> IDLE with zeros, and a following start runs cleanly.

Source files
------------

// File: rtl/approx_err_monitor.sv
// approx_err_monitor: accumulates error-distance and relative-error statistics of an approximate multiplier.
module approx_err_monitor #(
    parameter int N     = 8,
    parameter int P     = 2*N,
    parameter int CNT_W = 20,
    parameter int FRAC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_samples,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [P-1:0]            approx_p,
    input  logic [P-1:0]            exact_p,
    output logic                    busy,
    output logic                    done,
    output logic [P+CNT_W-1:0]      sum_ed,
    output logic [P-1:0]            max_ed,
    output logic [P-1:0]            max_approx,
    output logic [P-1:0]            max_exact,
    output logic [CNT_W-1:0]        err_cnt,
    output logic [CNT_W-1:0]        zero_cnt,
    output logic [P+FRAC+CNT_W-1:0] sum_red
);
    localparam int DW = P + FRAC;
    localparam int CW = $clog2(DW + 1);
    localparam logic [1:0] IDLE = 2'd0, ACCEPT = 2'd1, DIVIDE = 2'd2, DONE = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] remaining;
    logic [P-1:0]     rem, divisor, ed;
    logic [DW-1:0]    dvd, q_next;
    logic [CW-1:0]    step;
    logic [P:0]       trial, diff;
    logic             ge, accept;

    assign in_ready = state == ACCEPT;
    assign busy     = state == ACCEPT || state == DIVIDE;
    assign done     = state == DONE;
    assign accept   = in_ready && in_valid;
    assign ed       = approx_p >= exact_p ? approx_p - exact_p : exact_p - approx_p;
    // dvd shifts the dividend out of its top while quotient bits enter at the bottom
    assign trial    = {rem, dvd[DW-1]};
    assign diff     = trial - {1'b0, divisor};
    assign ge       = trial >= {1'b0, divisor};
    assign q_next   = {dvd[DW-2:0], ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            rem        <= '0;
            divisor    <= '0;
            dvd        <= '0;
            step       <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
            max_approx <= '0;
            max_exact  <= '0;
            err_cnt    <= '0;
            zero_cnt   <= '0;
            sum_red    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sum_ed     <= '0;
                        max_ed     <= '0;
                        max_approx <= '0;
                        max_exact  <= '0;
                        err_cnt    <= '0;
                        zero_cnt   <= '0;
                        sum_red    <= '0;
                        remaining  <= num_samples;
                        state      <= num_samples == '0 ? DONE : ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (accept) begin
                        remaining <= remaining - CNT_W'(1);
                        sum_ed    <= sum_ed + (P+CNT_W)'(ed);
                        if (ed != '0)
                            err_cnt <= err_cnt + CNT_W'(1);
                        if (exact_p == '0)
                            zero_cnt <= zero_cnt + CNT_W'(1);
                        if (ed > max_ed) begin
                            max_ed     <= ed;
                            max_approx <= approx_p;
                            max_exact  <= exact_p;
                        end
                        if (exact_p != '0 && ed != '0) begin
                            dvd     <= {ed, {FRAC{1'b0}}};
                            divisor <= exact_p;
                            rem     <= '0;
                            step    <= '0;
                            state   <= DIVIDE;
                        end else if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DIVIDE: begin
                    rem  <= ge ? diff[P-1:0] : trial[P-1:0];
                    dvd  <= q_next;
                    step <= step + CW'(1);
                    if (step == CW'(DW - 1)) begin
                        sum_red <= sum_red + (P+FRAC+CNT_W)'(q_next);
                        state   <= remaining == '0 ? DONE : ACCEPT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_err_monitor.sv
// tb_approx_err_monitor: directed vectors with hand-computed expectations for approx_err_monitor.
module tb_approx_err_monitor;
    localparam int N = 8, P = 16, CNT_W = 20, FRAC = 16;

    logic                    clk = 0;
    logic                    rst = 1;
    logic                    start = 0;
    logic [CNT_W-1:0]        num_samples = '0;
    logic                    in_valid = 0;
    logic                    in_ready;
    logic [P-1:0]            approx_p = '0;
    logic [P-1:0]            exact_p = '0;
    logic                    busy, done;
    logic [P+CNT_W-1:0]      sum_ed;
    logic [P-1:0]            max_ed, max_approx, max_exact;
    logic [CNT_W-1:0]        err_cnt, zero_cnt;
    logic [P+FRAC+CNT_W-1:0] sum_red;
    int checks = 0, failures = 0, lo;

    approx_err_monitor #(.N(N), .P(P), .CNT_W(CNT_W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .approx_p(approx_p), .exact_p(exact_p),
        .busy(busy), .done(done), .sum_ed(sum_ed), .max_ed(max_ed),
        .max_approx(max_approx), .max_exact(max_exact), .err_cnt(err_cnt),
        .zero_cnt(zero_cnt), .sum_red(sum_red)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1;
        num_samples = CNT_W'(n);
        tick();
        start = 0;
    endtask

    task automatic send(input int a, input int e, output int low);
        int w = 0;
        approx_p = P'(a);
        exact_p = P'(e);
        in_valid = 1;
        while (!in_ready && w < 200) begin
            tick();
            w++;
        end
        chk("ready_wait", 64'(w < 200), 64'd1);
        tick();
        in_valid = 0;
        low = 0;
        while (!in_ready && !done && low < 200) begin
            tick();
            low++;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sum_ed"}, 64'(sum_ed), 0);
        chk({tag, "_max_ed"}, 64'(max_ed), 0);
        chk({tag, "_max_ap"}, 64'(max_approx), 0);
        chk({tag, "_max_ex"}, 64'(max_exact), 0);
        chk({tag, "_err"}, 64'(err_cnt), 0);
        chk({tag, "_zero"}, 64'(zero_cnt), 0);
        chk({tag, "_red"}, 64'(sum_red), 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ready", 64'(in_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk_zero("rst");
        rst = 0;
        tick();

        do_start(1);
        chk("t1_busy", 64'(busy), 1);
        chk("t1_ready", 64'(in_ready), 1);
        do_start(5);
        chk("t1_ign_start", 64'(in_ready), 1);
        send(100, 100, lo);
        chk("t1_done", 64'(done), 1);
        chk("t1_busy_off", 64'(busy), 0);
        chk("t1_sum_ed", 64'(sum_ed), 0);
        chk("t1_err", 64'(err_cnt), 0);
        chk("t1_red", 64'(sum_red), 0);

        do_start(1);
        send(90, 100, lo);
        chk("t2_low", 64'(lo), 32);
        chk("t2_done", 64'(done), 1);
        chk("t2_sum_ed", 64'(sum_ed), 10);
        chk("t2_red", 64'(sum_red), 6553);
        chk("t2_err", 64'(err_cnt), 1);
        chk("t2_max_ed", 64'(max_ed), 10);
        chk("t2_max_ap", 64'(max_approx), 90);
        chk("t2_max_ex", 64'(max_exact), 100);
        repeat (3) tick();
        chk("t2_hold_done", 64'(done), 1);
        chk("t2_hold_red", 64'(sum_red), 6553);

        do_start(2);
        chk("t3_cleared", 64'(sum_ed), 0);
        send(5, 0, lo);
        chk("t3_nodiv_low", 64'(lo), 0);
        chk("t3_ready", 64'(in_ready), 1);
        send(130, 150, lo);
        chk("t3_low", 64'(lo), 32);
        chk("t3_done", 64'(done), 1);
        chk("t3_zero", 64'(zero_cnt), 1);
        chk("t3_sum_ed", 64'(sum_ed), 25);
        chk("t3_max_ed", 64'(max_ed), 20);
        chk("t3_max_ap", 64'(max_approx), 130);
        chk("t3_max_ex", 64'(max_exact), 150);
        chk("t3_red", 64'(sum_red), 8738);
        chk("t3_err", 64'(err_cnt), 2);

        do_start(2);
        send(80, 100, lo);
        chk("t4_low1", 64'(lo), 32);
        chk("t4_ready", 64'(in_ready), 1);
        send(220, 200, lo);
        chk("t4_low2", 64'(lo), 32);
        chk("t4_max_ed", 64'(max_ed), 20);
        chk("t4_max_ap", 64'(max_approx), 80);
        chk("t4_max_ex", 64'(max_exact), 100);
        chk("t4_sum_ed", 64'(sum_ed), 40);
        chk("t4_red", 64'(sum_red), 19660);

        do_start(0);
        chk("t5_done", 64'(done), 1);
        chk("t5_busy", 64'(busy), 0);
        chk_zero("t5");

        do_start(1);
        approx_p = 90;
        exact_p = 100;
        in_valid = 1;
        tick();
        in_valid = 0;
        repeat (5) tick();
        chk("t6_in_div", 64'(in_ready), 0);
        chk("t6_busy_div", 64'(busy), 1);
        rst = 1;
        start = 1;
        num_samples = 3;
        tick();
        start = 0;
        chk("t6_rst_ready", 64'(in_ready), 0);
        chk("t6_rst_busy", 64'(busy), 0);
        chk("t6_rst_done", 64'(done), 0);
        chk_zero("t6");
        rst = 0;
        tick();
        do_start(1);
        send(130, 150, lo);
        chk("t6_low", 64'(lo), 32);
        chk("t6_done", 64'(done), 1);
        chk("t6_sum_ed", 64'(sum_ed), 20);
        chk("t6_red", 64'(sum_red), 8738);
        chk("t6_max_ex", 64'(max_exact), 150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
